// File: rtl/tb_sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_rr_arbiter
//
// Shares one single-port, 1-cycle-latency testbench SRAM between NumReq
// requesters speaking a simple req/gnt/rvalid protocol. Typical users are an
// AXI-to-mem bridge and a backdoor preloader.
//
// A round-robin pointer picks one requester per cycle. Its byte address is
// turned into a word address and range-checked, and the access is forwarded to
// the SRAM when it is in range. One cycle later the response is steered back to
// the requester that issued it. An out-of-range access still gets a grant and a
// response, but with err set and zero data. It never touches the SRAM.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous reset, active low
//   req_i        request per requester
//   gnt_o        combinational grant, one-hot or zero
//   addr_i       byte address per requester (packed, requester 0 in the LSBs)
//   we_i         write enable per requester
//   wdata_i      write data per requester (packed)
//   be_i         byte enables per requester (packed)
//   rvalid_o     response valid, one cycle after the grant, reads and writes
//   err_o        out-of-range flag, qualified by rvalid_o
//   rdata_o      shared read data, meaningful only alongside a rvalid_o bit
//   mem_req_o    SRAM request
//   mem_we_o     SRAM write enable
//   mem_addr_o   SRAM word address
//   mem_wdata_o  SRAM write data
//   mem_be_o     SRAM byte enables
//   mem_rdata_i  SRAM read data, valid one cycle after mem_req_o
// -----------------------------------------------------------------------------
module tb_sram_rr_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 12,
    parameter int DataWidth = 64,
    parameter int NumWords  = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [NumReq-1:0]               err_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [$clog2(NumWords)-1:0]     mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int WordAw = $clog2(NumWords);
    localparam int ByteW  = DataWidth / 8;
    localparam int OffW   = $clog2(ByteW);
    localparam int WordW  = AddrWidth - OffW;
    localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic                 vld_q, vld_d;
    logic [PtrW-1:0]      idx_q, idx_d;
    logic                 oor_q, oor_d;

    logic                 winFound;
    logic [PtrW-1:0]      winIdx;
    logic [PtrW-1:0]      candIdx;
    int                   cand;
    logic [AddrWidth-1:0] winAddr;
    logic [WordW-1:0]     winWord;
    logic                 winInRange;

    // Round-robin search: walk the requesters starting at the priority
    // pointer and wrapping around, and take the first one asserting req_i.
    // Reset forces "no winner" so nothing is granted while rst_ni is low.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            candIdx = PtrW'(cand);
            if (!winFound && req_i[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
        if (!rst_ni) begin
            winFound = 1'b0;
        end
    end

    // Grant goes out in the same cycle the winner is chosen.
    always_comb begin
        gnt_o = '0;
        if (winFound) begin
            gnt_o[winIdx] = 1'b1;
        end
    end

    // Steer the winner's payload to the SRAM. The byte-offset bits are dropped
    // to form the word address. Any word at or beyond NumWords is rejected
    // rather than wrapped onto the low end of the array.
    always_comb begin
        winAddr     = addr_i[int'(winIdx)*AddrWidth +: AddrWidth];
        winWord     = winAddr[AddrWidth-1:OffW];
        winInRange  = (32'(winWord) < 32'(NumWords));
        mem_req_o   = winFound && winInRange;
        mem_we_o    = winFound && winInRange && we_i[winIdx];
        mem_addr_o  = winWord[WordAw-1:0];
        mem_wdata_o = wdata_i[int'(winIdx)*DataWidth +: DataWidth];
        mem_be_o    = be_i[int'(winIdx)*ByteW +: ByteW];
    end

    // Next-state: the pointer moves just past the winner so that winner has
    // lowest priority next time. With no grant the pointer holds. The response
    // tracker records who was served and whether the access was out of range.
    always_comb begin
        ptr_d = ptr_q;
        vld_d = winFound;
        idx_d = idx_q;
        oor_d = 1'b0;
        if (winFound) begin
            if (int'(winIdx) == NumReq - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = winIdx + PtrW'(1);
            end
            idx_d = winIdx;
            oor_d = !winInRange;
        end
    end

    // State registers with synchronous active-low reset. Clearing vld_q on
    // reset drops any response that was still in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            vld_q <= 1'b0;
            idx_q <= '0;
            oor_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
            oor_q <= oor_d;
        end
    end

    // Response routing: one rvalid pulse to the requester served last cycle.
    // Out-of-range responses carry err and zero data. The outputs are also
    // masked while reset is held, so a response registered just before reset
    // never appears.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (rst_ni && vld_q) begin
            rvalid_o[idx_q] = 1'b1;
            err_o[idx_q]    = oor_q;
            if (!oor_q) begin
                rdata_o = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_tb_sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tb_sram_rr_arbiter
//
// Bench for tb_sram_rr_arbiter with three requesters. A behavioural 1-cycle
// SRAM sits on the memory port. A separate shadow memory and a round-robin
// reference pointer predict every grant. Each grant pushes its expected
// response into a queue, and that entry is popped and compared on the
// following cycle.
// -----------------------------------------------------------------------------
module tb_tb_sram_rr_arbiter;

    localparam int NumReq    = 3;
    localparam int AddrWidth = 12;
    localparam int DataWidth = 64;
    localparam int NumWords  = 256;
    localparam int WordAw    = 8;
    localparam int ByteW     = 8;

    logic                          clk = 1'b0;
    logic                          rstN;
    logic [NumReq-1:0]             reqIn;
    logic [NumReq-1:0]             gntOut;
    logic [NumReq*AddrWidth-1:0]   addrIn;
    logic [NumReq-1:0]             weIn;
    logic [NumReq*DataWidth-1:0]   wdataIn;
    logic [NumReq*ByteW-1:0]       beIn;
    logic [NumReq-1:0]             rvalidOut;
    logic [NumReq-1:0]             errOut;
    logic [DataWidth-1:0]          rdataOut;
    logic                          memReq;
    logic                          memWe;
    logic [WordAw-1:0]             memAddr;
    logic [DataWidth-1:0]          memWdata;
    logic [ByteW-1:0]              memBe;
    logic [DataWidth-1:0]          memRdata;

    always #5 clk = ~clk;

    tb_sram_rr_arbiter #(
        .NumReq   (NumReq),
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth),
        .NumWords (NumWords)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .req_i      (reqIn),
        .gnt_o      (gntOut),
        .addr_i     (addrIn),
        .we_i       (weIn),
        .wdata_i    (wdataIn),
        .be_i       (beIn),
        .rvalid_o   (rvalidOut),
        .err_o      (errOut),
        .rdata_o    (rdataOut),
        .mem_req_o  (memReq),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .mem_be_o   (memBe),
        .mem_rdata_i(memRdata)
    );

    // Behavioural single-port SRAM with byte enables and one cycle of read
    // latency. It clears itself on its first clock edge.
    logic [DataWidth-1:0] envMem [NumWords];
    logic                 memInit = 1'b0;

    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < NumWords; i++) begin
                envMem[i] <= '0;
            end
            memInit <= 1'b1;
        end else if (memReq) begin
            if (memWe) begin
                for (int b = 0; b < ByteW; b++) begin
                    if (memBe[b]) begin
                        envMem[memAddr][b*8 +: 8] <= memWdata[b*8 +: 8];
                    end
                end
            end else begin
                memRdata <= envMem[memAddr];
            end
        end
    end

    typedef struct {
        int                   idx;
        bit                   oor;
        bit                   isRead;
        logic [DataWidth-1:0] data;
    } exp_t;

    exp_t                 expQ[$];
    logic [DataWidth-1:0] shadow [NumWords];

    logic                 rstDrv;
    logic                 reqDrv   [NumReq];
    logic [AddrWidth-1:0] addrDrv  [NumReq];
    logic                 weDrv    [NumReq];
    logic [DataWidth-1:0] wdataDrv [NumReq];
    logic [ByteW-1:0]     beDrv    [NumReq];

    int                   ptrM;
    int                   waitCnt  [NumReq];
    int                   lastWin;
    int                   grantCount;
    int                   checks;
    int                   passes;

    logic [NumReq-1:0]    obsGnt;
    logic [NumReq-1:0]    obsRvalid;
    logic [NumReq-1:0]    obsErr;
    logic [DataWidth-1:0] obsRdata;
    logic                 obsMemReq;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        rstN = rstDrv;
        for (int r = 0; r < NumReq; r++) begin
            reqIn[r]                         = reqDrv[r];
            addrIn[r*AddrWidth +: AddrWidth] = addrDrv[r];
            weIn[r]                          = weDrv[r];
            wdataIn[r*DataWidth +: DataWidth] = wdataDrv[r];
            beIn[r*ByteW +: ByteW]           = beDrv[r];
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then check the
    // response registered at that edge and the grant the model predicts.
    task automatic runCycle();
        exp_t                 e;
        int                   win;
        logic [8:0]           word;
        logic [DataWidth-1:0] merged;
        @(posedge clk);
        #1;
        applyStimulus();
        #1;
        obsGnt    = gntOut;
        obsRvalid = rvalidOut;
        obsErr    = errOut;
        obsRdata  = rdataOut;
        obsMemReq = memReq;

        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (rstDrv) begin
                checkOutput("rvalid", 64'(rvalidOut), 64'(1) << e.idx);
                checkOutput("err", 64'(errOut), e.oor ? (64'(1) << e.idx) : 64'(0));
                if (e.oor) begin
                    checkOutput("rdataOor", rdataOut, 64'(0));
                end else if (e.isRead) begin
                    checkOutput("rdata", rdataOut, e.data);
                end
            end else begin
                checkOutput("rvalidRst", 64'(rvalidOut), 64'(0));
                checkOutput("rdataRst", rdataOut, 64'(0));
            end
        end else begin
            checkOutput("rvalidIdle", 64'(rvalidOut), 64'(0));
            checkOutput("errIdle", 64'(errOut), 64'(0));
            checkOutput("rdataIdle", rdataOut, 64'(0));
        end

        win = -1;
        if (rstDrv) begin
            for (int k = 0; k < NumReq; k++) begin
                int c;
                c = (ptrM + k) % NumReq;
                if (win < 0 && reqDrv[c]) begin
                    win = c;
                end
            end
        end
        checkOutput("gnt", 64'(gntOut), (win >= 0) ? (64'(1) << win) : 64'(0));

        for (int r = 0; r < NumReq; r++) begin
            if (!reqDrv[r] || win == r || !rstDrv) begin
                waitCnt[r] = 0;
            end else if (win >= 0) begin
                waitCnt[r]++;
                checkOutput("fairness", 64'(waitCnt[r] <= NumReq - 1), 64'(1));
            end
        end

        if (win < 0) begin
            checkOutput("memReqIdle", 64'(memReq), 64'(0));
        end else begin
            word     = addrDrv[win][11:3];
            e.idx    = win;
            e.isRead = !weDrv[win];
            if (word < 9'(NumWords)) begin
                checkOutput("memReq", 64'(memReq), 64'(1));
                checkOutput("memAddr", 64'(memAddr), 64'(word[7:0]));
                checkOutput("memWe", 64'(memWe), 64'(weDrv[win]));
                e.oor  = 1'b0;
                e.data = shadow[word[7:0]];
                if (weDrv[win]) begin
                    checkOutput("memBe", 64'(memBe), 64'(beDrv[win]));
                    merged = shadow[word[7:0]];
                    for (int b = 0; b < ByteW; b++) begin
                        if (beDrv[win][b]) begin
                            merged[b*8 +: 8] = wdataDrv[win][b*8 +: 8];
                        end
                    end
                    shadow[word[7:0]] = merged;
                end
            end else begin
                checkOutput("memReqOor", 64'(memReq), 64'(0));
                e.oor  = 1'b1;
                e.data = '0;
            end
            expQ.push_back(e);
            ptrM = (win + 1) % NumReq;
            grantCount++;
        end
        if (!rstDrv) begin
            ptrM = 0;
        end
        lastWin = win;
    endtask

    // Present one operation on requester r and hold it until granted.
    task automatic doOp(input int r, input logic we, input logic [AddrWidth-1:0] addr,
                        input logic [DataWidth-1:0] wd, input logic [ByteW-1:0] be);
        bit got;
        got         = 1'b0;
        reqDrv[r]   = 1'b1;
        weDrv[r]    = we;
        addrDrv[r]  = addr;
        wdataDrv[r] = wd;
        beDrv[r]    = be;
        for (int t = 0; t < 20 && !got; t++) begin
            runCycle();
            if (lastWin == r) begin
                got = 1'b1;
            end
        end
        if (!got) begin
            checkOutput("opTimeout", 64'(0), 64'(1));
        end
        reqDrv[r] = 1'b0;
    endtask

    task automatic randomOp(input int r);
        int w;
        if ($urandom_range(0, 9) == 0) begin
            w = ($urandom_range(0, 7) == 0) ? 511 : int'($urandom_range(254, 259));
        end else begin
            w = int'($urandom_range(0, 15));
        end
        reqDrv[r]   = 1'b1;
        weDrv[r]    = 1'($urandom_range(0, 1));
        addrDrv[r]  = AddrWidth'(w * 8 + int'($urandom_range(0, 7)));
        wdataDrv[r] = {$urandom, $urandom};
        beDrv[r]    = 8'($urandom);
    endtask

    initial begin
        int startGrants;
        int budget;
        checks     = 0;
        passes     = 0;
        ptrM       = 0;
        lastWin    = -1;
        grantCount = 0;
        rstDrv     = 1'b0;
        for (int i = 0; i < NumWords; i++) begin
            shadow[i] = '0;
        end
        for (int r = 0; r < NumReq; r++) begin
            reqDrv[r]   = 1'b0;
            addrDrv[r]  = '0;
            weDrv[r]    = 1'b0;
            wdataDrv[r] = '0;
            beDrv[r]    = '0;
            waitCnt[r]  = 0;
        end
        applyStimulus();

        // Reset with a request pending: nothing may be granted or returned.
        reqDrv[0] = 1'b1;
        runCycle();
        runCycle();
        checkOutput("rstGnt", 64'(obsGnt), 64'(0));
        checkOutput("rstRvalid", 64'(obsRvalid), 64'(0));
        checkOutput("rstMemReq", 64'(obsMemReq), 64'(0));
        reqDrv[0] = 1'b0;
        rstDrv    = 1'b1;
        runCycle();

        $display("[TB] write/read word 1");
        doOp(0, 1'b1, 12'h008, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        checkOutput("t1wrGnt", 64'(obsGnt), 64'(1));
        doOp(0, 1'b0, 12'h008, 64'h0, 8'h00);
        checkOutput("t1rdGnt", 64'(obsGnt), 64'(1));
        runCycle();
        checkOutput("t1rvalid", 64'(obsRvalid), 64'(1));
        checkOutput("t1rdata", obsRdata, 64'hDEADBEEF_CAFEF00D);

        $display("[TB] alternating grants after reset");
        rstDrv = 1'b0;
        runCycle();
        runCycle();
        rstDrv     = 1'b1;
        reqDrv[0]  = 1'b1; weDrv[0] = 1'b0; addrDrv[0] = 12'h008;
        reqDrv[1]  = 1'b1; weDrv[1] = 1'b0; addrDrv[1] = 12'h010;
        for (int i = 0; i < 8; i++) begin
            runCycle();
            checkOutput("t2gnt", 64'(obsGnt), (i % 2 == 0) ? 64'(1) : 64'(2));
            if (i > 0) begin
                checkOutput("t2rvalid", 64'(obsRvalid), (i % 2 == 0) ? 64'(2) : 64'(1));
            end
        end
        reqDrv[0] = 1'b0;
        reqDrv[1] = 1'b0;
        runCycle();

        $display("[TB] partial byte-enable write");
        doOp(0, 1'b1, 12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        doOp(0, 1'b1, 12'h010, 64'h0, 8'h0F);
        doOp(0, 1'b0, 12'h010, 64'h0, 8'h00);
        runCycle();
        checkOutput("t3rdata", obsRdata, 64'hFFFF_FFFF_0000_0000);

        $display("[TB] range boundary");
        doOp(1, 1'b0, 12'h7F8, 64'h0, 8'h00);
        checkOutput("t4lastMemReq", 64'(obsMemReq), 64'(1));
        runCycle();
        checkOutput("t4lastErr", 64'(obsErr), 64'(0));
        doOp(1, 1'b1, 12'h800, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        checkOutput("t4oorWrMemReq", 64'(obsMemReq), 64'(0));
        doOp(1, 1'b0, 12'h800, 64'h0, 8'h00);
        checkOutput("t4oorRdMemReq", 64'(obsMemReq), 64'(0));
        runCycle();
        checkOutput("t4oorErr", 64'(obsErr), 64'(2));
        checkOutput("t4oorRdata", obsRdata, 64'(0));
        doOp(0, 1'b0, 12'h000, 64'h0, 8'h00);
        runCycle();
        checkOutput("t4word0", obsRdata, 64'(0));

        $display("[TB] reset drops pending response");
        doOp(1, 1'b0, 12'h008, 64'h0, 8'h00);
        rstDrv = 1'b0;
        runCycle();
        checkOutput("t5rvalidA", 64'(obsRvalid), 64'(0));
        runCycle();
        checkOutput("t5rvalidB", 64'(obsRvalid), 64'(0));
        rstDrv     = 1'b1;
        reqDrv[0]  = 1'b1; weDrv[0] = 1'b0; addrDrv[0] = 12'h008;
        reqDrv[1]  = 1'b1; weDrv[1] = 1'b0; addrDrv[1] = 12'h010;
        runCycle();
        checkOutput("t5rvalidC", 64'(obsRvalid), 64'(0));
        checkOutput("t5firstGnt", 64'(obsGnt), 64'(1));
        reqDrv[0] = 1'b0;
        reqDrv[1] = 1'b0;
        runCycle();
        runCycle();

        $display("[TB] randomised traffic");
        startGrants = grantCount;
        budget      = 0;
        while (grantCount - startGrants < 10000 && budget < 40000) begin
            runCycle();
            budget++;
            if (lastWin >= 0) begin
                reqDrv[lastWin] = 1'b0;
            end
            for (int r = 0; r < NumReq; r++) begin
                if (!reqDrv[r] && $urandom_range(0, 3) != 0) begin
                    randomOp(r);
                end
            end
        end
        if (grantCount - startGrants < 10000) begin
            checkOutput("t6budget", 64'(grantCount - startGrants), 64'(10000));
        end
        for (int r = 0; r < NumReq; r++) begin
            reqDrv[r] = 1'b0;
        end
        runCycle();
        runCycle();
        checkOutput("queueEmpty", 64'(expQ.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
